// File: rtl/round_stream_ctrl.sv
// Frame sequencer between CAM1 and the rounding stage: strobes perform_round per accepted beat
// and buffers rounded results in a small FIFO. Optional clamp: define ROUND_STREAM_SAT_EN.
module round_stream_ctrl #(
    parameter int unsigned INPUT_LEN  = 64,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ready,
    output logic [DATA_W-1:0] rnd_in,
    output logic              perform_round,
    input  logic [DATA_W-1:0] round_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef ROUND_STREAM_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int unsigned CntW = (INPUT_LEN > 1) ? $clog2(INPUT_LEN) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(INPUT_LEN - 1);
    localparam logic [OccW-1:0] FullCnt  = OccW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]   count_q, count_d;
    logic              fifo_full, fifo_empty;
    logic              accept, pop, is_last;
    logic [DATA_W-1:0] wr_data;

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);
    assign is_last    = (beat_cnt_q == LastBeat);

    assign accept        = cam_valid & cam_ready;
    assign perform_round = accept;
    assign rnd_in        = cam_data;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid & out_ready;
    assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q][DATA_W-1:0];
    assign out_last  = !fifo_empty & mem_q[rd_ptr_q][DATA_W];

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (accept && is_last) state_d = StDrain;
            StDrain: if (count_d == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        cam_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            StIdle:  busy = 1'b0;
            StRun:   cam_ready = !fifo_full;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + OccW'(1);
            2'b01:   count_d = count_q - OccW'(1);
            default: ;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == StIdle && start) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = is_last ? '0 : beat_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            count_q    <= count_d;
            if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage needs no reset: out_data/out_last are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= {is_last, wr_data};
    end

`ifdef ROUND_STREAM_SAT_EN
    localparam logic signed [DATA_W-1:0] SatMax = DATA_W'(127);
    localparam logic signed [DATA_W-1:0] SatMin = DATA_W'(-128);

    logic signed [DATA_W-1:0] rnd_s;
    logic                     sat_hi, sat_lo;
    logic                     sat_flag_q, sat_flag_d;

    assign rnd_s   = round_data;
    assign sat_hi  = (rnd_s > SatMax);
    assign sat_lo  = (rnd_s < SatMin);
    assign wr_data = sat_hi ? SatMax : (sat_lo ? SatMin : round_data);

    always_comb begin
        sat_flag_d = sat_flag_q;
        if (state_q == StIdle && start) begin
            sat_flag_d = 1'b0;
        end else if (accept && (sat_hi || sat_lo)) begin
            sat_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    assign wr_data = round_data;
`endif

endmodule

// File: doc/round_stream_ctrl.md
Name: round_stream_ctrl

Overview:
- Frame sequencer for the CAM1 -> rounding stage.
- Accepts one frame of INPUT_LEN CAM1 beats over a valid/ready handshake and drives the rounding datapath's perform_round strobe once per accepted beat.
- Captures each rounded result in a small FIFO and presents it downstream over valid/ready, tagging the last beat of each frame.
- Tracks the frame in its own beat counter and reports frame completion.

Parameters:
- INPUT_LEN, 64, beats per frame (must be >= 2).
- DATA_W, 32, width of the CAM1 and rounded data.
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle frame start request.
- cam_valid  in  1  CAM1 beat available.
- cam_data  in  DATA_W  CAM1 output beat.
- cam_ready  out  1  controller accepts the beat this cycle.
- rnd_in  out  DATA_W  operand to the rounding datapath; equals cam_data.
- perform_round  out  1  rounding strobe; high exactly on accepted beats.
- round_data  in  DATA_W  rounded result, combinational from rnd_in.
- out_valid  out  1  FIFO head valid.
- out_data  out  DATA_W  FIFO head data.
- out_last  out  1  FIFO head is the frame's final beat.
- out_ready  in  1  downstream accepts the head.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset. While reset is high at a clk edge:
  - state <= IDLE, beat_cnt <= 0, FIFO emptied.
  - All outputs are 0: cam_ready, perform_round, out_valid, out_last, busy, done. out_data is 0.
  - Reset mid-frame aborts the frame; no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cam_ready = 0.
  - start=1 -> RUN, beat_cnt <= 0.
  - start is ignored in every other state.
- RUN:
  - cam_ready = !fifo_full. fifo_full is count == FIFO_DEPTH, from registered state.
  - accept = cam_valid & cam_ready.
  - perform_round = accept (combinational). rnd_in = cam_data at all times.
  - On accept: push {last = (beat_cnt == INPUT_LEN-1), round_data} into the FIFO and increment beat_cnt.
  - Accepting beat INPUT_LEN-1 -> DRAIN, beat_cnt <= 0.
- DRAIN:
  - cam_ready = 0.
  - Stay until the FIFO is empty after this cycle's pop; then -> DONE.
- DONE:
  - done = 1 for exactly one cycle, then -> IDLE.
  - start asserted while in DONE is ignored.
- FIFO:
  - out_valid = (count != 0). out_data and out_last read the head entry combinationally.
  - Pop on out_valid & out_ready.
  - Pop and push in the same cycle: count unchanged, both take effect.
  - When full, a pop frees space only from the next cycle; there is no same-cycle fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a beat accepted in cycle N appears at the FIFO head with out_valid=1 in cycle N+1, provided the FIFO was empty.
- perform_round is 0 on every non-accept cycle, including stall cycles with cam_valid=1 and cam_ready=0.
- out_data holds 0 when the FIFO is empty.

Optional Feature:
- Macro: ROUND_STREAM_SAT_EN.
- Defined: round_data is clamped to the signed 8-bit range [-128, 127] and sign-extended to DATA_W before the FIFO write.
- Sticky output sat_flag (1 bit, added only when defined) is set when any clamp occurs. sat_flag clears on reset or on start.
- Undefined: round_data is stored unmodified and no sat_flag port exists.

Test Plan:
- Basic frame: INPUT_LEN=4, out_ready=1. start, then 4 back-to-back beats with round_data = -1, -2, -3, -4.
  -> perform_round high for 4 cycles; out_data sequence -1, -2, -3, -4 each one cycle after accept; out_last only on -4; done pulses 2 cycles after the last accept; busy falls with done.
- Backpressure: out_ready=0, FIFO_DEPTH=4, INPUT_LEN=8.
  -> cam_ready drops after 4 accepts and perform_round stays 0 while cam_valid=1.
  -> Raise out_ready: the frame completes, all 8 results in order, no loss or duplication.
- Simultaneous push/pop at full: FIFO holds 4 entries, out_ready=1, cam_valid=1.
  -> Cycle 1: pop only. Cycle 2: push and pop together, count stays 3.
  -> Entry order is preserved across pointer wrap.
- Ignored start: pulse start during RUN and during DONE.
  -> No restart and beat_cnt unaffected; a fresh start in IDLE begins a new frame with out_last on beat INPUT_LEN-1.
- Reset mid-frame: assert reset after 2 of 4 beats, with 1 entry still in the FIFO.
  -> Next cycle all outputs are 0 and the FIFO is empty; done never pulses; a new start runs a clean frame.
- ROUND_STREAM_SAT_EN: round_data = -200, then 50.
  -> Stored values -128 and 50; sat_flag = 1 and stays set; start clears it.
